// File: rtl/ahb_pkg.sv
// AHB-Lite encodings, SRAM slave state type and a byte-lane merge helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef logic [2:0] hsize_t;
  localparam hsize_t HSIZE_BYTE = 3'd0;
  localparam hsize_t HSIZE_HALF = 3'd1;
  localparam hsize_t HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sram_state_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_sram_bytelane.sv
// Little-endian lane strobe from HSIZE/HADDR[1:0]; flags oversize or misaligned accesses.
// Purely combinational, no backpressure.
module ahb_sram_bytelane (
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       illegal
);
  import ahb_pkg::*;

  always_comb begin
    strb    = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb    = 4'b1111;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: legal transfer takes WAIT_STATES+1 data-phase cycles, illegal one a 2-cycle ERROR.
// Stalls only through HREADYOUT; AHB_SRAM_PROT_EN rejects user-mode writes to the upper half of memory.
module ahb_sram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);
  import ahb_pkg::*;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH) * 32'd4;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH];

  sram_state_t   state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          ph_vld, ph_write;
  logic [AW-1:0] ph_idx;
  logic [3:0]    ph_strb;

  logic [31:0]   offset;
  logic          accept, acc_illegal, align_bad, prot_viol;
  logic [3:0]    acc_strb;
  logic [AW-1:0] acc_idx, rd_idx;
  logic [31:0]   cur_word, wr_word, rd_word;
  logic          wr_en, rd_load;
  logic          unused_sigs;

  assign offset  = HADDR - BASE_ADDR;
  assign acc_idx = offset[AW+1:2];
  assign accept  = HSEL & HREADY & HTRANS[1];

  ahb_sram_bytelane u_lane (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .strb    (acc_strb),
    .illegal (align_bad)
  );

`ifdef AHB_SRAM_PROT_EN
  assign prot_viol   = HWRITE & ~HPROT[1] & (offset >= (MEM_BYTES >> 1));
  assign unused_sigs = ^{HTRANS[0], HBURST, HPROT[3:2], HPROT[0]};
`else
  assign prot_viol   = 1'b0;
  assign unused_sigs = ^{HTRANS[0], HBURST, HPROT};
`endif

  assign acc_illegal = align_bad | (offset >= MEM_BYTES) | prot_viol;

  // A read accepted while a write completes to the same word sees the merged data.
  assign cur_word = mem[ph_idx];
  assign wr_word  = lane_merge(cur_word, HWDATA, ph_strb);
  assign wr_en    = nRST & ph_vld & ph_write & (state == ST_DATA);
  assign rd_idx   = accept ? acc_idx : ph_idx;
  assign rd_word  = (wr_en && (ph_idx == rd_idx)) ? wr_word : mem[rd_idx];
  assign rd_load  = (state_nxt == ST_DATA) & (accept ? ~HWRITE : ~ph_write);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt <= 4'd1) begin
          state_nxt = ST_DATA;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = HRESP_ERROR;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      if (acc_illegal) begin
        state_nxt = ST_ERR1;
      end else if (WS != 4'd0) begin
        state_nxt = ST_WAIT;
        cnt_nxt   = WS;
      end else begin
        state_nxt = ST_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      ph_vld   <= 1'b0;
      ph_write <= 1'b0;
      ph_idx   <= '0;
      ph_strb  <= 4'b0000;
      HRDATA   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        ph_vld   <= ~acc_illegal;
        ph_write <= HWRITE;
        ph_idx   <= acc_idx;
        ph_strb  <= acc_strb;
      end else if (state_nxt == ST_IDLE) begin
        ph_vld <= 1'b0;
      end
      if (rd_load) HRDATA <= rd_word;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[ph_idx] <= wr_word;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: cycle table on a zero-wait instance, hand sequences on a 3-wait instance.
module tb_ahb_sram_slave;

  localparam logic [31:0] B    = 32'h2000_0000;
  localparam logic [1:0]  IDL  = 2'b00;
  localparam logic [1:0]  BSY  = 2'b01;
  localparam logic [1:0]  NS   = 2'b10;
  localparam logic [1:0]  OK   = 2'b00;
  localparam logic [1:0]  ER   = 2'b01;
  localparam logic [3:0]  PRIV = 4'b0011;
  localparam logic [3:0]  USR  = 4'b0001;
`ifdef AHB_SRAM_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        sel0, sel3;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        ro0, ro3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rdata0, rdata3;
  logic        hready0, hready3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Single-slave interconnect: bus HREADY is this slave's HREADYOUT.
  assign hready0 = ro0;
  assign hready3 = ro3;

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(B)) u_ws0 (
    .CLK(clk), .nRST(nrst), .HSEL(sel0), .HREADY(hready0), .HTRANS(htrans),
    .HWRITE(hwrite), .HADDR(haddr), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HWDATA(hwdata), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(B)) u_ws3 (
    .CLK(clk), .nRST(nrst), .HSEL(sel3), .HREADY(hready3), .HTRANS(htrans),
    .HWRITE(hwrite), .HADDR(haddr), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HWDATA(hwdata), .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rdata3)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] off;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wd;
    logic        erdy;
    logic [1:0]  eresp;
    logic        chk;
    logic [31:0] edat;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [31:0] off, input logic [2:0] size,
                              input logic [3:0] prot, input logic [31:0] wd,
                              input logic erdy, input logic [1:0] eresp,
                              input logic chk, input logic [31:0] edat);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.off = off; v.size = size; v.prot = prot;
    v.wd = wd; v.erdy = erdy; v.eresp = eresp; v.chk = chk; v.edat = edat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts HREADYOUT-low cycles of the 3-wait instance; returns at the negedge of its ready cycle.
  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (ro3) break;
      n++;
      if (n > 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_timeout: HREADYOUT low for %0d cycles, expected ready within 40", name, n);
        break;
      end
      tick();
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] off);
    htrans = NS; hwrite = wr; haddr = B + off; hsize = 3'd2;
  endtask

  initial begin
    int n;
    nrst = 1'b0; sel0 = 1'b0; sel3 = 1'b0; htrans = IDL; hwrite = 1'b0;
    haddr = B; hsize = 3'd2; hburst = 3'd0; hprot = PRIV; hwdata = 32'd0;

    tbl[0]  = mk(0, IDL, 0, 'h000, 2, PRIV, 'h0,        1, OK, 1, 'h0);
    tbl[1]  = mk(1, NS,  1, 'h000, 2, PRIV, 'h0,        1, OK, 0, 'h0);
    tbl[2]  = mk(1, NS,  1, 'h010, 2, PRIV, 'h0BADF00D, 1, OK, 0, 'h0);
    tbl[3]  = mk(1, NS,  0, 'h010, 2, PRIV, 'h12345678, 1, OK, 0, 'h0);
    tbl[4]  = mk(1, IDL, 0, 'h000, 2, PRIV, 'h0,        1, OK, 1, 'h12345678);
    tbl[5]  = mk(1, NS,  1, 'h013, 0, PRIV, 'h0,        1, OK, 1, 'h12345678);
    tbl[6]  = mk(1, NS,  0, 'h010, 2, PRIV, 'hAB000000, 1, OK, 0, 'h0);
    tbl[7]  = mk(1, NS,  1, 'h010, 1, PRIV, 'h0,        1, OK, 1, 'hAB345678);
    tbl[8]  = mk(1, BSY, 0, 'h010, 1, PRIV, 'h0000BEEF, 1, OK, 0, 'h0);
    tbl[9]  = mk(1, NS,  1, 'h012, 1, PRIV, 'h0,        1, OK, 0, 'h0);
    tbl[10] = mk(1, NS,  0, 'h010, 2, PRIV, 'hCAFE0000, 1, OK, 0, 'h0);
    tbl[11] = mk(1, IDL, 0, 'h000, 2, PRIV, 'h0,        1, OK, 1, 'hCAFEBEEF);
    tbl[12] = mk(0, NS,  1, 'h010, 2, PRIV, 'h0,        1, OK, 1, 'hCAFEBEEF);
    tbl[13] = mk(1, NS,  1, 'h002, 2, PRIV, 'h55555555, 1, OK, 0, 'h0);
    tbl[14] = mk(1, IDL, 0, 'h000, 2, PRIV, 'hDEADBEEF, 0, ER, 0, 'h0);
    tbl[15] = mk(1, NS,  1, 'h001, 1, PRIV, 'h0,        1, ER, 0, 'h0);
    tbl[16] = mk(1, IDL, 0, 'h000, 2, PRIV, 'hDEADBEEF, 0, ER, 0, 'h0);
    tbl[17] = mk(1, NS,  1, 'h1000, 0, PRIV, 'h0,       1, ER, 0, 'h0);
    tbl[18] = mk(1, IDL, 0, 'h000, 2, PRIV, 'hFFFFFFFF, 0, ER, 0, 'h0);
    tbl[19] = mk(1, NS,  1, 'h000, 3, PRIV, 'h0,        1, ER, 0, 'h0);
    tbl[20] = mk(1, IDL, 0, 'h000, 2, PRIV, 'hFFFFFFFF, 0, ER, 0, 'h0);
    tbl[21] = mk(1, NS,  0, 'h000, 2, PRIV, 'h0,        1, ER, 0, 'h0);
    tbl[22] = mk(1, NS,  0, 'h010, 2, PRIV, 'h0,        1, OK, 1, 'h0BADF00D);
    tbl[23] = mk(1, IDL, 0, 'h000, 2, PRIV, 'h0,        1, OK, 1, 'hCAFEBEEF);
    tbl[24] = mk(1, NS,  1, 'h800, 2, PRIV, 'h0,        1, OK, 0, 'h0);
    tbl[25] = mk(1, NS,  1, 'h800, 2, USR,  'hA5A5A5A5, 1, OK, 0, 'h0);
    tbl[26] = mk(1, IDL, 0, 'h000, 2, USR,  'h5A5A5A5A, PROT ? 1'b0 : 1'b1, PROT ? ER : OK, 0, 'h0);
    tbl[27] = mk(1, IDL, 0, 'h000, 2, PRIV, 'h0,        1, PROT ? ER : OK, 0, 'h0);
    tbl[28] = mk(1, NS,  0, 'h800, 2, USR,  'h0,        1, OK, 0, 'h0);
    tbl[29] = mk(1, IDL, 0, 'h000, 2, PRIV, 'h0,        1, OK, 1,
                 PROT ? 32'hA5A5A5A5 : 32'h5A5A5A5A);

    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("rst_ws0_hreadyout", 32'(ro0), 32'd1);
    check("rst_ws0_hresp", 32'(resp0), 32'(OK));
    check("rst_ws0_hrdata", rdata0, 32'd0);
    check("rst_ws3_hreadyout", 32'(ro3), 32'd1);
    check("rst_ws3_hresp", 32'(resp3), 32'(OK));
    check("rst_ws3_hrdata", rdata3, 32'd0);
    tick();

    for (int i = 0; i < 30; i++) begin
      sel0 = tbl[i].sel; htrans = tbl[i].trans; hwrite = tbl[i].wr;
      haddr = B + tbl[i].off; hsize = tbl[i].size; hprot = tbl[i].prot; hwdata = tbl[i].wd;
      @(negedge clk);
      check($sformatf("v%0d_hreadyout", i), 32'(ro0), 32'(tbl[i].erdy));
      check($sformatf("v%0d_hresp", i), 32'(resp0), 32'(tbl[i].eresp));
      if (tbl[i].chk) check($sformatf("v%0d_hrdata", i), rdata0, tbl[i].edat);
      tick();
    end

    // Three wait states: write then pipelined read held until the ready cycle.
    sel0 = 1'b0; sel3 = 1'b1; hprot = PRIV;
    addr_phase(1'b1, 'h20);
    tick();
    hwdata = 32'h55AA1234;
    addr_phase(1'b0, 'h20);
    wait_ready("ws3_wr", n);
    check("ws3_wr_wait_cycles", 32'(n), 32'd3);
    check("ws3_wr_hresp", 32'(resp3), 32'(OK));
    tick();
    htrans = IDL;
    wait_ready("ws3_rd", n);
    check("ws3_rd_wait_cycles", 32'(n), 32'd3);
    check("ws3_rd_hrdata", rdata3, 32'h55AA1234);
    check("ws3_rd_hresp", 32'(resp3), 32'(OK));
    tick();

    // Reset during the wait of a write drops it.
    addr_phase(1'b1, 'h20);
    tick();
    hwdata = 32'h11111111; htrans = IDL;
    @(negedge clk);
    check("rstw_in_wait", 32'(ro3), 32'd0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    @(negedge clk);
    check("rstw_hreadyout", 32'(ro3), 32'd1);
    check("rstw_hresp", 32'(resp3), 32'(OK));
    check("rstw_hrdata", rdata3, 32'd0);
    tick();
    addr_phase(1'b0, 'h20);
    tick();
    htrans = IDL;
    wait_ready("rstw_rd", n);
    check("rstw_rd_wait_cycles", 32'(n), 32'd3);
    check("rstw_rd_hrdata", rdata3, 32'h55AA1234);
    tick();
    sel3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
